gshare_branch_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 29 ++
 rtl/gshare_branch_predictor_if.sv | 31 +++
 rtl/bp_sat_counter_table.sv | 32 +++
 rtl/gshare_branch_predictor.sv | 82 ++++++++
 tb/tb_gshare_branch_predictor.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and counter arithmetic for the gshare predictor and its PHT.
// Latency: n/a (types and functions only); backpressure: n/a.
package bp_pkg;

    localparam int BP_PC_W  = 16;
    localparam int BP_IDX_W = 4;
    localparam int BP_TAG_W = BP_PC_W - BP_IDX_W - 1;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
    } btb_entry_t;

    // Weakly not-taken: one below the taken threshold.
    function automatic int ctr_init(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int ctr_sat_step(input int val, input logic up, input int w);
        int max_val;
        max_val = (1 << w) - 1;
        if (up) begin
            return (val == max_val) ? val : val + 1;
        end
        return (val == 0) ? val : val - 1;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Fetch/resolve bundle between the CPU pipeline (master) and the predictor (slave).
// Latency: combinational prediction; backpressure: none, enable stalls fetch.
interface gshare_branch_predictor_if
    import bp_pkg::*;
#(
    parameter int PC_W  = BP_PC_W,
    parameter int IDX_W = BP_IDX_W
);
    logic             enable;
    logic [PC_W-1:0]  pc_fetch;
    logic             pred_hit;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic [IDX_W-1:0] pred_idx;
    logic             res_valid;
    logic [PC_W-1:0]  res_pc;
    logic [IDX_W-1:0] res_idx;
    logic             res_taken;
    logic [PC_W-1:0]  res_target;
    logic             res_mispredicted;

    modport master (
        output enable, pc_fetch, res_valid, res_pc, res_idx, res_taken, res_target, res_mispredicted,
        input  pred_hit, pred_taken, pred_target, pred_idx
    );

    modport slave (
        input  enable, pc_fetch, res_valid, res_pc, res_idx, res_taken, res_target, res_mispredicted,
        output pred_hit, pred_taken, pred_target, pred_idx
    );
endinterface

// File: rtl/bp_sat_counter_table.sv
// Pattern history table of saturating counters, async read, one synchronous update port.
// Latency: 0-cycle read, update visible next cycle; backpressure: none.
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_inc
);
    localparam int N_ENT = 1 << IDX_W;

    logic [CTR_W-1:0] ctr_q [N_ENT];

    assign rd_ctr = ctr_q[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                ctr_q[i] <= CTR_W'(ctr_init(CTR_W));
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= CTR_W'(ctr_sat_step(int'(ctr_q[wr_idx]), wr_inc, CTR_W));
        end
    end
endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor plus tagged direct-mapped BTB with speculative GHR recovery.
// Latency: prediction 0 cycles from pc_fetch; backpressure: enable=0 freezes speculative history.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W  = BP_PC_W,
    parameter int IDX_W = BP_IDX_W,
    parameter int CTR_W = 2,
    parameter int GHR_W = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    gshare_branch_predictor_if.slave bp
);
    localparam int N_ENT = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 1;

    btb_entry_t       btb_q [N_ENT];
    btb_entry_t       fetch_entry;
    logic [GHR_W-1:0] ghr_spec_q;
    logic [GHR_W-1:0] ghr_arch_q;
    logic [GHR_W-1:0] ghr_arch_nxt;
    logic [IDX_W-1:0] fetch_set;
    logic [IDX_W-1:0] res_set;
    logic [TAG_W-1:0] fetch_tag;
    logic [CTR_W-1:0] pht_ctr;
    logic             unused_res_pc_lsb;

    // Instructions are halfword aligned, so bit 0 carries no index or tag information.
    assign fetch_set         = bp.pc_fetch[IDX_W:1];
    assign fetch_tag         = bp.pc_fetch[PC_W-1:IDX_W+1];
    assign res_set           = bp.res_pc[IDX_W:1];
    assign unused_res_pc_lsb = bp.res_pc[0];

    assign fetch_entry    = btb_q[fetch_set];
    assign bp.pred_idx    = fetch_set ^ IDX_W'(ghr_spec_q);
    assign bp.pred_hit    = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    assign bp.pred_taken  = bp.pred_hit && pht_ctr[CTR_W-1];
    assign bp.pred_target = bp.pred_taken ? fetch_entry.target : bp.pc_fetch + PC_W'(2);

    bp_sat_counter_table #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_pht (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (bp.pred_idx),
        .rd_ctr (pht_ctr),
        .wr_en  (bp.res_valid),
        .wr_idx (bp.res_idx),
        .wr_inc (bp.res_taken)
    );

    assign ghr_arch_nxt = GHR_W'({ghr_arch_q, bp.res_taken});

    // Misprediction recovery wins over the speculative shift from the same cycle's fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr_spec_q <= '0;
            ghr_arch_q <= '0;
        end else begin
            if (bp.res_valid) begin
                ghr_arch_q <= ghr_arch_nxt;
            end
            if (bp.res_valid && bp.res_mispredicted) begin
                ghr_spec_q <= ghr_arch_nxt;
            end else if (bp.enable && bp.pred_hit) begin
                ghr_spec_q <= GHR_W'({ghr_spec_q, bp.pred_taken});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                btb_q[i].valid <= 1'b0;
            end
        end else if (bp.res_valid && bp.res_taken) begin
            btb_q[res_set] <= '{valid: 1'b1, tag: bp.res_pc[PC_W-1:IDX_W+1], target: bp.res_target};
        end
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench: directed scenarios plus random traffic against an array-based predictor model.
module tb_gshare_branch_predictor;
    localparam int PC_W = 16, IDX_W = 4, CTR_W = 2, GHR_W = 4;
    localparam int NSET = 16, CTR_MAX = 3, TAKEN_MIN = 2, HIST_MOD = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    gshare_branch_predictor_if #(.PC_W(PC_W), .IDX_W(IDX_W)) bp_if ();

    gshare_branch_predictor #(
        .PC_W (PC_W), .IDX_W (IDX_W), .CTR_W (CTR_W), .GHR_W (GHR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    hit;
        bit    taken;
        int    tgt;
        int    idx;
        string nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    int m_pht [NSET];
    bit m_v   [NSET];
    int m_tag [NSET];
    int m_tgt [NSET];
    int m_spec, m_arch;

    function automatic void model_reset();
        for (int i = 0; i < NSET; i++) begin
            m_pht[i] = TAKEN_MIN - 1;
            m_v[i]   = 1'b0;
        end
        m_spec = 0;
        m_arch = 0;
    endfunction

    function automatic exp_t model_predict(input int pc, input string nm);
        exp_t e;
        int   s;
        s       = (pc / 2) % NSET;
        e.hit   = m_v[s] && (m_tag[s] == pc / 32);
        e.idx   = s ^ m_spec;
        e.taken = e.hit && (m_pht[e.idx] >= TAKEN_MIN);
        e.tgt   = e.taken ? m_tgt[s] : (pc + 2) % 65536;
        e.nm    = nm;
        return e;
    endfunction

    function automatic void model_clock(input bit en, input int rpc, input bit rv, input int ridx,
                                        input bit rt, input int rtgt, input bit rm, input bit rstn,
                                        input exp_t p);
        int ns;
        if (!rstn) begin
            model_reset();
            return;
        end
        ns = m_spec;
        if (en && p.hit) ns = (m_spec * 2 + int'(p.taken)) % HIST_MOD;
        if (rv) begin
            m_arch = (m_arch * 2 + int'(rt)) % HIST_MOD;
            if (rm) ns = m_arch;
            if (rt) begin
                if (m_pht[ridx] < CTR_MAX) m_pht[ridx]++;
                m_v[(rpc / 2) % NSET]   = 1'b1;
                m_tag[(rpc / 2) % NSET] = rpc / 32;
                m_tgt[(rpc / 2) % NSET] = rtgt;
            end else if (m_pht[ridx] > 0) begin
                m_pht[ridx]--;
            end
        end
        m_spec = ns;
    endfunction

    task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // mode 0: no check, 1: model expectation, 2: directed constants (dh/dt/dtg/di)
    task automatic step(input bit en, input int pc, input bit rv, input int rpc, input int ridx,
                        input bit rt, input int rtgt, input bit rm, input bit rstn, input int mode,
                        input string nm, input bit dh = 0, input bit dt = 0, input int dtg = 0,
                        input int di = 0);
        exp_t p, d;
        bp_if.enable           = en;
        bp_if.pc_fetch         = 16'(pc);
        bp_if.res_valid        = rv;
        bp_if.res_pc           = 16'(rpc);
        bp_if.res_idx          = 4'(ridx);
        bp_if.res_taken        = rt;
        bp_if.res_target       = 16'(rtgt);
        bp_if.res_mispredicted = rm;
        rst_n                  = rstn;
        p = model_predict(pc, nm);
        if (mode == 1) begin
            exp_q.push_back(p);
        end else if (mode == 2) begin
            d.hit = dh; d.taken = dt; d.tgt = dtg; d.idx = di; d.nm = nm;
            exp_q.push_back(d);
        end
        @(posedge clk);
        model_clock(en, rpc, rv, ridx, rt, rtgt, rm, rstn, p);
        #1;
    endtask

    task automatic fetch(input bit en, input int pc, input string nm,
                         input bit dh, input bit dt, input int dtg, input int di);
        step(en, pc, 0, 0, 0, 0, 0, 0, 1, 2, nm, dh, dt, dtg, di);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            compare({mon_e.nm, "/hit"},   32'(bp_if.pred_hit),    32'(mon_e.hit));
            compare({mon_e.nm, "/taken"}, 32'(bp_if.pred_taken),  32'(mon_e.taken));
            compare({mon_e.nm, "/tgt"},   32'(bp_if.pred_target), 32'(mon_e.tgt));
            compare({mon_e.nm, "/idx"},   32'(bp_if.pred_idx),    32'(mon_e.idx));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Saturation script on PHT[5]: res_valid, res_taken, expected taken at fetch of 0x000A.
    bit sat_rv [13] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    bit sat_rt [13] = '{1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    bit sat_tk [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    initial begin
        model_reset();
        step(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        step(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, "rst");

        // Reset state, history-dependent index, tag alias.
        fetch(0, 'h0004, "s1_reset", 0, 0, 'h0006, 'h2);
        step(0, 'h0004, 1, 'h0004, 'h2, 1, 'h0040, 1, 1, 2, "s2_same_cycle", 0, 0, 'h0006, 'h2);
        fetch(0, 'h0004, "s2_after", 1, 0, 'h0006, 'h3);
        fetch(0, 'h0006, "s2_hist_idx", 0, 0, 'h0008, 'h2);
        fetch(0, 'h0024, "s4_alias", 0, 0, 'h0026, 'h3);

        // Saturation both ends.
        step(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        for (int i = 0; i < 13; i++) begin
            step(0, 'h000A, sat_rv[i], 'h000A, 'h5, sat_rt[i], 'h0100, 0, 1, 2, $sformatf("s3_sat%0d", i),
                 i != 0, sat_tk[i], sat_tk[i] ? 'h0100 : 'h000C, 'h5);
        end

        // Simultaneous fetch shift and mispredict recovery.
        step(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        step(0, 4, 1, 4, 'h1, 1, 'h0040, 0, 1, 1, "s5_train");
        step(0, 4, 1, 4, 'h3, 1, 'h0040, 0, 1, 1, "s5_train");
        for (int i = 0; i < 4; i++) step(0, 4, 1, 4, 'hF, 0, 0, 0, 1, 1, "s5_train");
        step(0, 4, 1, 4, 'hE, 1, 'h0040, 1, 1, 1, "s5_train");
        fetch(1, 'h0004, "s5_shift", 1, 1, 'h0040, 'h3);
        step(1, 'h0004, 1, 'h0030, 'hD, 0, 0, 1, 1, 2, "s5_both", 1, 1, 'h0040, 'h1);
        fetch(0, 'h0004, "s5_recovered", 1, 0, 'h0006, 'h0);
        step(0, 'h0004, 1, 'h0004, 'h0, 1, 'h0040, 0, 1, 2, "s5_stall", 1, 0, 'h0006, 'h0);
        fetch(0, 'h0004, "s5_frozen", 1, 1, 'h0040, 'h0);

        // Reset mid-run with a resolve in the reset cycle.
        step(1, 4, 1, 'h0024, 'h2, 1, 'h0080, 1, 0, 0, "rst");
        fetch(0, 'h0004, "s6_pc4", 0, 0, 'h0006, 'h2);
        fetch(0, 'h0024, "s6_dropped", 0, 0, 'h0026, 'h2);
        fetch(0, 'h000A, "s6_cleared", 0, 0, 'h000C, 'h5);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 1),
                 $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1),
                 $urandom_range(0, 65535), $urandom_range(0, 9) < 3, $urandom_range(0, 99) != 0,
                 1, "rand");
        end

        @(negedge clk);
        compare("drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
